pixel_resp_meter: RTL and testbench
===================================

Name: pixel_resp_meter

Overview:
- Parametrised next-generation pixel response-time meter. Alternately drives a dark/bright test frame and times the photosensor transitions between two programmable thresholds.
- Reports averaged rise and fall times over 2^AVG_LOG2 runs, with timeout detection.
- Sits between the photosensor ADC sample path and the CPU-visible result registers of the display tester.

Parameters:
SAMPLE_W, 8, width of sensor sample and thresholds
CNT_W, 32, width of per-measurement cycle counter and averaged results
SETTLE_CYCLES, 50000000, hold time after each measurement before the frame toggles
TIMEOUT_CYCLES, 100000000, max cycles in a WAIT+CNT phase before abort
AVG_LOG2, 2, log2 of measurements averaged per direction (0 = no averaging)

Ports:
clk  in  1  system clock
resetn  in  1  reset, asynchronous, active-low
sample  in  SAMPLE_W  sensor brightness, valid every cycle
thr_lo  in  SAMPLE_W  low threshold (e.g. 10 %); software guarantees thr_lo < thr_hi
thr_hi  in  SAMPLE_W  high threshold (e.g. 90 %)
loop_en  in  1  run continuous measurement loop
frame_index  out  1  test pattern select: 0 = dark, 1 = bright
rise_avg  out  CNT_W  averaged rise time in clk cycles
fall_avg  out  CNT_W  averaged fall time in clk cycles
rise_valid  out  1  one-cycle pulse when rise_avg updates
fall_valid  out  1  one-cycle pulse when fall_avg updates
timeout  out  1  sticky; set on any phase timeout, cleared by reset or IDLE entry
busy  out  1  high in any state except IDLE
rise_min, rise_max, fall_min, fall_max  out  CNT_W each  extrema (optional feature)

Behaviour:
- Reset: all outputs 0, state IDLE, counters and accumulators 0. Asserting resetn low mid-measurement aborts immediately; no partial result is published.
- States: IDLE, F_WAIT, F_CNT, F_SETTLE, R_WAIT, R_CNT, R_SETTLE. frame_index is registered: 0 in F_*, 1 in R_*, holds last value in IDLE.
- IDLE, with loop_en=1:
  - sample > thr_hi -> F_WAIT.
  - else sample < thr_lo -> R_WAIT.
  - else stay in IDLE.
- F_WAIT: start condition sample <= thr_hi.
  - If sample < thr_lo in the same cycle: raw = 0 -> F_SETTLE.
  - Else if start condition: counter <= 1 -> F_CNT.
- F_CNT: stop condition sample < thr_lo.
  - If stop: raw = counter -> F_SETTLE.
  - Else counter++, saturating at 2^CNT_W-1.
- R_WAIT / R_CNT: mirror of F_WAIT / F_CNT.
  - Start condition: sample >= thr_lo.
  - Stop condition: sample > thr_hi.
  - Same-cycle start and stop gives raw = 0.
  - Exits to R_SETTLE.
- Measurement value = (cycle stop first seen) - (cycle start first seen).
- Timeout: a phase counter starts at 0 on WAIT entry and increments through WAIT+CNT. On reaching TIMEOUT_CYCLES: set timeout, discard the measurement (not accumulated), go to the matching SETTLE.
- SETTLE: hold frame_index for SETTLE_CYCLES cycles, then:
  - loop_en=0 -> IDLE.
  - F_SETTLE -> R_WAIT.
  - R_SETTLE -> F_WAIT.
- Accumulation:
  - Each valid raw is added to the per-direction accumulator (CNT_W+AVG_LOG2 bits, no overflow possible) and its count is incremented.
  - When count reaches 2^AVG_LOG2: avg <= acc >> AVG_LOG2 (truncating), valid pulses one cycle later, acc and count clear.
- Latency: rise_avg/fall_avg and valid update 2 cycles after the stop-crossing sample.
- loop_en falling mid-phase has no effect until the end of the current SETTLE.
- IDLE entry clears accumulators and counts; published averages are retained.

Optional Feature:
- Macro: PIXEL_RESP_MINMAX_EN.
- Defined: rise_min/rise_max/fall_min/fall_max track extrema of valid raws within the current averaging window.
  - Published together with the average, on the same valid pulse.
  - min resets to all-ones and max resets to 0 at window start.
- Undefined: the four ports are tied to 0 and no extrema logic is built.

Test Plan:
All scenarios use SAMPLE_W=8, SETTLE_CYCLES=16, TIMEOUT_CYCLES=64, AVG_LOG2=1, thr_lo=26, thr_hi=229.
1. Fall basic: sample=255, loop_en=1; after F_WAIT set sample=200 for 10 cycles then 10 -> raw fall = 10; after the second identical run fall_avg=10 and fall_valid pulses once.
2. Averaging truncation: rise runs of 7 then 8 cycles -> rise_avg=7, rise_valid single pulse.
3. Step jump: F_WAIT with sample 255 -> 0 in one cycle -> raw=0 accumulated; two such runs -> fall_avg=0.
4. Timeout: in R_WAIT hold sample=10 -> after 64 cycles timeout=1, enters R_SETTLE, frame_index stays 1, no rise_valid; next F phase proceeds normally.
5. Reset mid-F_CNT: drop resetn asynchronously -> frame_index=0, busy=0, all averages 0 immediately without a clock edge.
6. loop_en=0 during R_CNT -> R_CNT and R_SETTLE complete, then IDLE, busy=0. With PIXEL_RESP_MINMAX_EN and runs of 5 and 9 cycles -> min=5, max=9.

Source files
------------

// File: rtl/pixel_resp_meter_if.sv
// ============================================================================
// pixel_resp_meter_if : sensor/threshold inputs and result outputs of the meter
// Rev 1.0
// ============================================================================
`default_nettype none

interface pixel_resp_meter_if #(
  parameter int SAMPLE_W = 8,
  parameter int CNT_W    = 32
);
  logic [SAMPLE_W-1:0] sample;
  logic [SAMPLE_W-1:0] thr_lo;
  logic [SAMPLE_W-1:0] thr_hi;
  logic                loop_en;
  logic                frame_index;
  logic [CNT_W-1:0]    rise_avg;
  logic [CNT_W-1:0]    fall_avg;
  logic                rise_valid;
  logic                fall_valid;
  logic                timeout;
  logic                busy;
  logic [CNT_W-1:0]    rise_min;
  logic [CNT_W-1:0]    rise_max;
  logic [CNT_W-1:0]    fall_min;
  logic [CNT_W-1:0]    fall_max;

  modport master (
    output sample, thr_lo, thr_hi, loop_en,
    input  frame_index, rise_avg, fall_avg, rise_valid, fall_valid, timeout, busy,
    input  rise_min, rise_max, fall_min, fall_max
  );

  modport slave (
    input  sample, thr_lo, thr_hi, loop_en,
    output frame_index, rise_avg, fall_avg, rise_valid, fall_valid, timeout, busy,
    output rise_min, rise_max, fall_min, fall_max
  );
endinterface

`default_nettype wire

// File: rtl/pixel_resp_meter.sv
// ============================================================================
// pixel_resp_meter : times photosensor fall/rise between two thresholds and
// averages 2^AVG_LOG2 runs; define PIXEL_RESP_MINMAX_EN for window extrema.
// Rev 1.0
// ============================================================================
`default_nettype none

module pixel_resp_meter #(
  parameter int SAMPLE_W       = 8,
  parameter int CNT_W          = 32,
  parameter int SETTLE_CYCLES  = 50000000,
  parameter int TIMEOUT_CYCLES = 100000000,
  parameter int AVG_LOG2       = 2
) (
  input  logic               clk,
  input  logic               resetn,
  pixel_resp_meter_if.slave  io_meter
);

  localparam int ACC_W = CNT_W + AVG_LOG2;
  localparam int NUM_W = AVG_LOG2 + 1;
  localparam int PH_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int ST_W  = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_F_WAIT   = 3'd1,
    S_F_CNT    = 3'd2,
    S_F_SETTLE = 3'd3,
    S_R_WAIT   = 3'd4,
    S_R_CNT    = 3'd5,
    S_R_SETTLE = 3'd6
  } state_t;

  function automatic logic f_meas(input state_t s);
    return (s == S_F_WAIT) || (s == S_F_CNT) || (s == S_R_WAIT) || (s == S_R_CNT);
  endfunction

  function automatic logic f_settle(input state_t s);
    return (s == S_F_SETTLE) || (s == S_R_SETTLE);
  endfunction

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic [PH_W-1:0]       r_phase;
  logic [ST_W-1:0]       r_settle;
  logic                  r_frame;
  logic                  r_timeout;
  logic [CNT_W-1:0]      r_raw;
  logic                  r_raw_vld;
  logic                  r_raw_rise;
  logic                  w_raw_set;
  logic [CNT_W-1:0]      w_raw_val;
  logic                  w_tmo_set;
  logic                  w_above_hi;
  logic                  w_below_lo;
  logic                  w_phase_last;
  logic                  w_settle_last;
  logic                  w_idle_entry;

  assign w_above_hi    = io_meter.sample > io_meter.thr_hi;
  assign w_below_lo    = io_meter.sample < io_meter.thr_lo;
  assign w_phase_last  = r_phase == PH_W'(TIMEOUT_CYCLES - 1);
  assign w_settle_last = r_settle == ST_W'(SETTLE_CYCLES - 1);
  assign w_cnt_inc     = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_idle_entry  = (w_state_nxt == S_IDLE) && (r_state != S_IDLE);

  // A completed crossing in the last allowed cycle wins over the timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_raw_set   = 1'b0;
    w_raw_val   = '0;
    w_tmo_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_meter.loop_en) begin
          if (w_above_hi)      w_state_nxt = S_F_WAIT;
          else if (w_below_lo) w_state_nxt = S_R_WAIT;
        end
      end
      S_F_WAIT: begin
        if (w_below_lo) begin
          w_raw_set   = 1'b1;
          w_state_nxt = S_F_SETTLE;
        end else if (w_phase_last) begin
          w_tmo_set   = 1'b1;
          w_state_nxt = S_F_SETTLE;
        end else if (!w_above_hi) begin
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = S_F_CNT;
        end
      end
      S_F_CNT: begin
        if (w_below_lo) begin
          w_raw_set   = 1'b1;
          w_raw_val   = r_cnt;
          w_state_nxt = S_F_SETTLE;
        end else if (w_phase_last) begin
          w_tmo_set   = 1'b1;
          w_state_nxt = S_F_SETTLE;
        end else begin
          w_cnt_nxt   = w_cnt_inc;
        end
      end
      S_F_SETTLE: begin
        if (w_settle_last) w_state_nxt = io_meter.loop_en ? S_R_WAIT : S_IDLE;
      end
      S_R_WAIT: begin
        if (w_above_hi) begin
          w_raw_set   = 1'b1;
          w_state_nxt = S_R_SETTLE;
        end else if (w_phase_last) begin
          w_tmo_set   = 1'b1;
          w_state_nxt = S_R_SETTLE;
        end else if (!w_below_lo) begin
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = S_R_CNT;
        end
      end
      S_R_CNT: begin
        if (w_above_hi) begin
          w_raw_set   = 1'b1;
          w_raw_val   = r_cnt;
          w_state_nxt = S_R_SETTLE;
        end else if (w_phase_last) begin
          w_tmo_set   = 1'b1;
          w_state_nxt = S_R_SETTLE;
        end else begin
          w_cnt_nxt   = w_cnt_inc;
        end
      end
      S_R_SETTLE: begin
        if (w_settle_last) w_state_nxt = io_meter.loop_en ? S_F_WAIT : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_phase    <= '0;
      r_settle   <= '0;
      r_frame    <= 1'b0;
      r_timeout  <= 1'b0;
      r_raw      <= '0;
      r_raw_vld  <= 1'b0;
      r_raw_rise <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_phase    <= (f_meas(r_state) && f_meas(w_state_nxt)) ? r_phase + PH_W'(1) : '0;
      r_settle   <= (f_settle(r_state) && (w_state_nxt == r_state)) ? r_settle + ST_W'(1) : '0;
      if (w_state_nxt == S_F_WAIT || w_state_nxt == S_F_CNT || w_state_nxt == S_F_SETTLE)
        r_frame <= 1'b0;
      else if (w_state_nxt == S_R_WAIT || w_state_nxt == S_R_CNT || w_state_nxt == S_R_SETTLE)
        r_frame <= 1'b1;
      if (w_tmo_set)         r_timeout <= 1'b1;
      else if (w_idle_entry) r_timeout <= 1'b0;
      r_raw      <= w_raw_val;
      r_raw_vld  <= w_raw_set;
      r_raw_rise <= (r_state == S_R_WAIT) || (r_state == S_R_CNT);
    end
  end

  // Index 0 = fall, 1 = rise.
  logic [1:0][ACC_W-1:0] r_acc;
  logic [1:0][NUM_W-1:0] r_num;
  logic [1:0][CNT_W-1:0] r_avg;
  logic [1:0]            r_vld;
  logic [ACC_W-1:0]      w_sum;
  logic                  w_win_last;

  assign w_sum      = r_acc[r_raw_rise] + ACC_W'(r_raw);
  assign w_win_last = r_num[r_raw_rise] == NUM_W'((1 << AVG_LOG2) - 1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_acc <= '0;
      r_num <= '0;
      r_avg <= '0;
      r_vld <= '0;
    end else begin
      r_vld <= '0;
      if (r_raw_vld) begin
        if (w_win_last) begin
          r_avg[r_raw_rise] <= CNT_W'(w_sum >> AVG_LOG2);
          r_vld[r_raw_rise] <= 1'b1;
          r_acc[r_raw_rise] <= '0;
          r_num[r_raw_rise] <= '0;
        end else begin
          r_acc[r_raw_rise] <= w_sum;
          r_num[r_raw_rise] <= r_num[r_raw_rise] + NUM_W'(1);
        end
      end
      if (w_idle_entry) begin
        r_acc <= '0;
        r_num <= '0;
      end
    end
  end

  assign io_meter.frame_index = r_frame;
  assign io_meter.busy        = r_state != S_IDLE;
  assign io_meter.timeout     = r_timeout;
  assign io_meter.fall_avg    = r_avg[0];
  assign io_meter.rise_avg    = r_avg[1];
  assign io_meter.fall_valid  = r_vld[0];
  assign io_meter.rise_valid  = r_vld[1];

`ifdef PIXEL_RESP_MINMAX_EN
  logic [1:0][CNT_W-1:0] r_win_min;
  logic [1:0][CNT_W-1:0] r_win_max;
  logic [1:0][CNT_W-1:0] r_min;
  logic [1:0][CNT_W-1:0] r_max;
  logic [CNT_W-1:0]      w_min_new;
  logic [CNT_W-1:0]      w_max_new;

  assign w_min_new = (r_raw < r_win_min[r_raw_rise]) ? r_raw : r_win_min[r_raw_rise];
  assign w_max_new = (r_raw > r_win_max[r_raw_rise]) ? r_raw : r_win_max[r_raw_rise];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_win_min <= '1;
      r_win_max <= '0;
      r_min     <= '0;
      r_max     <= '0;
    end else begin
      if (r_raw_vld) begin
        if (w_win_last) begin
          r_min[r_raw_rise]     <= w_min_new;
          r_max[r_raw_rise]     <= w_max_new;
          r_win_min[r_raw_rise] <= '1;
          r_win_max[r_raw_rise] <= '0;
        end else begin
          r_win_min[r_raw_rise] <= w_min_new;
          r_win_max[r_raw_rise] <= w_max_new;
        end
      end
      if (w_idle_entry) begin
        r_win_min <= '1;
        r_win_max <= '0;
      end
    end
  end

  assign io_meter.fall_min = r_min[0];
  assign io_meter.fall_max = r_max[0];
  assign io_meter.rise_min = r_min[1];
  assign io_meter.rise_max = r_max[1];
`else
  assign io_meter.fall_min = '0;
  assign io_meter.fall_max = '0;
  assign io_meter.rise_min = '0;
  assign io_meter.rise_max = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pixel_resp_meter.sv
// ============================================================================
// tb_pixel_resp_meter : randomized fall/rise runs against a transaction model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pixel_resp_meter;

  localparam int SAMPLE_W = 8;
  localparam int CNT_W    = 32;
  localparam int SETTLE   = 16;
  localparam int TMO      = 64;
  localparam int AVG_LOG2 = 1;
  localparam int THR_LO   = 26;
  localparam int THR_HI   = 229;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  pixel_resp_meter_if #(.SAMPLE_W(SAMPLE_W), .CNT_W(CNT_W)) mif ();

  pixel_resp_meter #(
    .SAMPLE_W(SAMPLE_W), .CNT_W(CNT_W), .SETTLE_CYCLES(SETTLE),
    .TIMEOUT_CYCLES(TMO), .AVG_LOG2(AVG_LOG2)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .io_meter(mif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint unsigned avg;
    longint unsigned mn;
    longint unsigned mx;
    int unsigned     due;
  } exp_t;

  exp_t            exp_r[$];
  exp_t            exp_f[$];
  longint unsigned win_r[$];
  longint unsigned win_f[$];
  longint unsigned last_ravg = 0, last_favg = 0;
  longint unsigned last_rmin = 0, last_rmax = 0, last_fmin = 0, last_fmax = 0;
  bit              exp_tmo = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic logic [7:0] rnd_lvl(input int lo, input int hi);
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return 8'(lo);
    if (r == 1) return 8'(hi);
    return 8'($urandom_range(hi, lo));
  endfunction

  function automatic logic [7:0] lvl_dark();   return rnd_lvl(0, THR_LO - 1);      endfunction
  function automatic logic [7:0] lvl_bright(); return rnd_lvl(THR_HI + 1, 255);    endfunction
  function automatic logic [7:0] lvl_mid();    return rnd_lvl(THR_LO, THR_HI);     endfunction
  function automatic logic [7:0] lvl_pre(input bit rise); return rise ? lvl_dark() : lvl_bright(); endfunction
  function automatic logic [7:0] lvl_end(input bit rise); return rise ? lvl_bright() : lvl_dark(); endfunction

  task automatic drv(input logic [7:0] v);
    @(negedge clk);
    mif.sample = v;
  endtask

  // Averages are published once per window of 2^AVG_LOG2 accepted runs.
  task automatic model_add(input bit rise, input longint unsigned raw, input int unsigned due);
    longint unsigned w[$];
    longint unsigned sum;
    exp_t e;
    if (rise) win_r.push_back(raw); else win_f.push_back(raw);
    if (rise) w = win_r; else w = win_f;
    if (w.size() == (1 << AVG_LOG2)) begin
      sum = 0;
      e.mn = w[0];
      e.mx = w[0];
      foreach (w[i]) begin
        sum += w[i];
        if (w[i] < e.mn) e.mn = w[i];
        if (w[i] > e.mx) e.mx = w[i];
      end
      e.avg = sum / (1 << AVG_LOG2);
      e.due = due;
      if (rise) begin
        exp_r.push_back(e); win_r.delete();
        last_ravg = e.avg; last_rmin = e.mn; last_rmax = e.mx;
      end else begin
        exp_f.push_back(e); win_f.delete();
        last_favg = e.avg; last_fmin = e.mn; last_fmax = e.mx;
      end
    end
  endtask

  task automatic check_published();
    chk("rise_avg_hold", mif.rise_avg, last_ravg);
    chk("fall_avg_hold", mif.fall_avg, last_favg);
`ifdef PIXEL_RESP_MINMAX_EN
    chk("rise_min_hold", mif.rise_min, last_rmin);
    chk("rise_max_hold", mif.rise_max, last_rmax);
    chk("fall_min_hold", mif.fall_min, last_fmin);
    chk("fall_max_hold", mif.fall_max, last_fmax);
`else
    chk("minmax_tied", {mif.rise_min | mif.rise_max | mif.fall_min | mif.fall_max}, 0);
`endif
  endtask

  always @(negedge clk) begin : mon_rise
    exp_t e;
    if (resetn && mif.rise_valid) begin
      if (exp_r.size() == 0) chk("rise_valid_unexpected", 1, 0);
      else begin
        e = exp_r.pop_front();
        chk("rise_avg", mif.rise_avg, e.avg);
        chk("rise_latency", cyc, e.due);
`ifdef PIXEL_RESP_MINMAX_EN
        chk("rise_min", mif.rise_min, e.mn);
        chk("rise_max", mif.rise_max, e.mx);
`endif
      end
    end
  end

  always @(negedge clk) begin : mon_fall
    exp_t e;
    if (resetn && mif.fall_valid) begin
      if (exp_f.size() == 0) chk("fall_valid_unexpected", 1, 0);
      else begin
        e = exp_f.pop_front();
        chk("fall_avg", mif.fall_avg, e.avg);
        chk("fall_latency", cyc, e.due);
`ifdef PIXEL_RESP_MINMAX_EN
        chk("fall_min", mif.fall_min, e.mn);
        chk("fall_max", mif.fall_max, e.mx);
`endif
      end
    end
  end

  // k > 0: k intermediate cycles; k == 0: direct step; k < 0: hold until timeout.
  task automatic phase(input bit rise, input int k, input bit drop_loop);
    int d0;
    int n;
    d0 = $urandom_range(1, 5);
    if (k < 0) begin
      n = 0;
      while (!mif.timeout && n < TMO + SETTLE + 40) begin
        drv(lvl_pre(rise));
        n++;
      end
      chk("timeout_set", mif.timeout, 1);
      chk("timeout_window", (n >= TMO && n <= TMO + SETTLE + 2), 1);
      chk("timeout_frame", mif.frame_index, rise);
      exp_tmo = 1'b1;
      return;
    end
    repeat (SETTLE + 2 + d0) drv(lvl_pre(rise));
    check_published();
    chk("busy_in_phase", mif.busy, 1);
    chk("timeout_sticky", mif.timeout, exp_tmo);
    for (int i = 0; i < k; i++) begin
      drv(lvl_mid());
      if (drop_loop && i == 0) mif.loop_en = 1'b0;
    end
    drv(lvl_end(rise));
    chk("frame_index", mif.frame_index, rise);
    model_add(rise, longint'(k), cyc + 2);
    if (drop_loop) begin
      repeat (SETTLE + 3) drv(lvl_end(rise));
      chk("idle_busy", mif.busy, 0);
      chk("idle_frame", mif.frame_index, rise);
      chk("idle_timeout_clr", mif.timeout, 0);
      win_r.delete();
      win_f.delete();
      exp_tmo = 1'b0;
    end
  endtask

  task automatic reset_mid_fall();
    repeat (SETTLE + 4) drv(lvl_pre(1'b0));
    repeat (5) drv(lvl_mid());
    #2 resetn = 1'b0;
    #1;
    chk("rst_frame", mif.frame_index, 0);
    chk("rst_busy", mif.busy, 0);
    chk("rst_rise_avg", mif.rise_avg, 0);
    chk("rst_fall_avg", mif.fall_avg, 0);
    chk("rst_timeout", mif.timeout, 0);
    chk("rst_minmax", {mif.rise_min | mif.rise_max | mif.fall_min | mif.fall_max}, 0);
    win_r.delete(); win_f.delete(); exp_r.delete(); exp_f.delete();
    last_ravg = 0; last_favg = 0;
    last_rmin = 0; last_rmax = 0; last_fmin = 0; last_fmax = 0;
    exp_tmo = 1'b0;
    drv(lvl_bright());
    drv(lvl_bright());
    resetn = 1'b1;
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: observed no end expected end within budget");
    $fatal(1, "bench watchdog expired");
  end

  initial begin : stim
    bit rise;
    int dir_k[10];
    int nph;
    int r;
    int k;
    dir_k = '{10, 7, 10, 8, 0, 5, 0, 9, 3, -1};
    mif.sample  = 8'd255;
    mif.thr_lo  = 8'(THR_LO);
    mif.thr_hi  = 8'(THR_HI);
    mif.loop_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_frame", mif.frame_index, 0);
    chk("reset_busy", mif.busy, 0);
    chk("reset_valid", {mif.rise_valid, mif.fall_valid}, 0);
    chk("reset_timeout", mif.timeout, 0);
    check_published();
    resetn = 1'b1;
    drv(8'd255);
    drv(8'd255);
    chk("idle_no_loop", mif.busy, 0);
    mif.loop_en = 1'b1;

    rise = 1'b0;
    foreach (dir_k[i]) begin
      phase(rise, dir_k[i], 1'b0);
      rise = ~rise;
    end
    phase(rise, 4, 1'b0);
    rise = ~rise;
    phase(rise, 6, 1'b1);
    rise = ~rise;
    mif.loop_en = 1'b1;

    for (int s = 0; s < 6; s++) begin
      nph = $urandom_range(4, 9);
      for (int p = 0; p < nph; p++) begin
        r = $urandom_range(0, 7);
        if (r == 0 && !exp_tmo) k = -1;
        else if (r == 1)        k = 0;
        else                    k = $urandom_range(1, 30);
        phase(rise, k, 1'b0);
        rise = ~rise;
      end
      if (s == 3) begin
        if (rise) begin
          phase(rise, $urandom_range(1, 30), 1'b0);
          rise = 1'b0;
        end
        reset_mid_fall();
      end else begin
        phase(rise, $urandom_range(1, 30), 1'b1);
        rise = ~rise;
        mif.loop_en = 1'b1;
      end
    end

    repeat (SETTLE + 8) drv(lvl_pre(rise));
    chk("pending_rise", exp_r.size(), 0);
    chk("pending_fall", exp_f.size(), 0);
    check_published();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
